// File: rtl/ram_pkg.sv
// ram_pkg: shared types, constants and helpers for the byte-enable dual-port RAM
package ram_pkg;
    typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    function automatic int byte_count(input int width);
        return width / 8;
    endfunction
    function automatic logic parity8(input logic [7:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: clear FSM that walks every word once after reset or on request
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int MEMORY_DEPTH  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    output logic                     busy_o,
    output logic                     clr_we_o,
    output logic [ADDRESS_WIDTH-1:0] clr_addr_o
);
    ram_state_t state;
    logic [ADDRESS_WIDTH-1:0] cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RAM_CLEAR;
            cnt   <= '0;
        end else if (clear_i) begin
            state <= RAM_CLEAR;
            cnt   <= '0;
        end else if (state == RAM_CLEAR) begin
            state <= cnt == ADDRESS_WIDTH'(MEMORY_DEPTH - 1) ? RAM_READY : RAM_CLEAR;
            cnt   <= cnt == ADDRESS_WIDTH'(MEMORY_DEPTH - 1) ? '0 : cnt + 1'b1;
        end
    end
    assign busy_o     = state == RAM_CLEAR;
    assign clr_we_o   = busy_o;
    assign clr_addr_o = cnt;
endmodule

// File: rtl/ram_dp_be.sv
// ram_dp_be: 1W/1R byte-enable RAM with clear sequencer; RAM_PARITY_EN adds per-byte even parity
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MEMORY_DEPTH  = 32,
    parameter int RDW_MODE      = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    output logic                       busy_o,
    input  logic                       we_i,
    input  logic [DATA_WIDTH/8-1:0]    be_i,
    input  logic [ADDRESS_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]      wr_data_i,
    input  logic                       re_i,
    input  logic [ADDRESS_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    output logic                       rd_valid_o,
    output logic                       parity_err_o
`ifdef RAM_PARITY_EN
    ,
    input  logic                       err_inject_i
`endif
);
    localparam int NB = byte_count(DATA_WIDTH);
    logic clr_we;
    logic [ADDRESS_WIDTH-1:0] clr_addr;
    ram_clear_seq #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .MEMORY_DEPTH(MEMORY_DEPTH)) u_seq (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .busy_o(busy_o), .clr_we_o(clr_we), .clr_addr_o(clr_addr)
    );
    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic wr_in, rd_in, wr_ok, rd_ok, bypass;
    assign wr_in  = {1'b0, wr_addr_i} < (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);
    assign rd_in  = {1'b0, rd_addr_i} < (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);
    assign wr_ok  = !busy_o && !clear_i && we_i && wr_in;
    assign rd_ok  = !busy_o && !clear_i && re_i;
    assign bypass = RDW_MODE != RDW_OLD && wr_ok && wr_addr_i == rd_addr_i;
`ifdef RAM_PARITY_EN
    logic [NB-1:0] par [MEMORY_DEPTH];
    logic [NB-1:0] wr_par, rd_par, rd_chk;
`endif
    // bypass merges enabled write lanes (and their fresh parity) into the read word
    always_comb begin
        rd_word = rd_in ? mem[rd_addr_i] : '0;
`ifdef RAM_PARITY_EN
        rd_par = rd_in ? par[rd_addr_i] : '0;
`endif
        for (int k = 0; k < NB; k++) begin
`ifdef RAM_PARITY_EN
            wr_par[k] = parity8(wr_data_i[8*k+:8]) ^ err_inject_i;
            rd_par[k] = bypass && be_i[k] ? wr_par[k] : rd_par[k];
`endif
            rd_word[8*k+:8] = bypass && be_i[k] ? wr_data_i[8*k+:8] : rd_word[8*k+:8];
        end
`ifdef RAM_PARITY_EN
        for (int k = 0; k < NB; k++) rd_chk[k] = parity8(rd_word[8*k+:8]);
`endif
    end
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
`ifdef RAM_PARITY_EN
            par[clr_addr] <= '0;
`endif
        end else if (wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (be_i[k]) begin
                    mem[wr_addr_i][8*k+:8] <= wr_data_i[8*k+:8];
`ifdef RAM_PARITY_EN
                    par[wr_addr_i][k] <= wr_par[k];
`endif
                end
            end
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_ok;
            if (rd_ok) rd_data_o <= rd_word;
        end
    end
`ifdef RAM_PARITY_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) parity_err_o <= 1'b0;
        else parity_err_o <= rd_ok && rd_in && rd_par != rd_chk;
    end
`else
    assign parity_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: directed tables plus random traffic against a word-level RAM model
module tb_ram_dp_be;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, clear, we, re, inj;
    logic [3:0] be;
    logic [4:0] wa, ra;
    logic [31:0] wd;
    logic busy [2];
    logic rv [2];
    logic pe [2];
    logic [31:0] rdd [2];
    ram_dp_be #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .MEMORY_DEPTH(32), .RDW_MODE(0)) u0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[0]), .we_i(we), .be_i(be),
        .wr_addr_i(wa), .wr_data_i(wd), .re_i(re), .rd_addr_i(ra), .rd_data_o(rdd[0]),
        .rd_valid_o(rv[0]), .parity_err_o(pe[0])
`ifdef RAM_PARITY_EN
        , .err_inject_i(inj)
`endif
    );
    ram_dp_be #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .MEMORY_DEPTH(20), .RDW_MODE(1)) u1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[1]), .we_i(we), .be_i(be),
        .wr_addr_i(wa), .wr_data_i(wd), .re_i(re), .rd_addr_i(ra), .rd_data_o(rdd[1]),
        .rd_valid_o(rv[1]), .parity_err_o(pe[1])
`ifdef RAM_PARITY_EN
        , .err_inject_i(inj)
`endif
    );
    int checks = 0, failures = 0;
    int dep [2] = '{32, 20};
    int rdw [2] = '{0, 1};
    logic [31:0] mm [2][32];
    logic [3:0] mp [2][32];
    int bc [2];
    logic [31:0] erd [2];
    logic erv [2], epe [2];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask
    function automatic logic [3:0] bpar(input logic [31:0] w);
        logic [3:0] p;
        for (int k = 0; k < 4; k++) p[k] = ^w[8*k+:8];
        return p;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            bc[i] = dep[i]; erd[i] = '0; erv[i] = 1'b0; epe[i] = 1'b0;
        end
    endtask
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                bc[i] = dep[i]; erd[i] = '0; erv[i] = 1'b0; epe[i] = 1'b0;
            end else if (bc[i] > 0) begin
                erv[i] = 1'b0; epe[i] = 1'b0;
                bc[i] = clear ? dep[i] : bc[i] - 1;
                if (bc[i] == 0)
                    for (int a = 0; a < 32; a++) begin mm[i][a] = '0; mp[i][a] = '0; end
            end else if (clear) begin
                bc[i] = dep[i]; erv[i] = 1'b0; epe[i] = 1'b0;
            end else begin
                erv[i] = re; epe[i] = 1'b0;
                if (re) begin
                    logic [31:0] w;
                    logic [3:0] p;
                    w = '0; p = '0;
                    if (int'(ra) < dep[i]) begin
                        w = mm[i][ra]; p = mp[i][ra];
                        if (rdw[i] == 1 && we && wa == ra)
                            for (int k = 0; k < 4; k++)
                                if (be[k]) begin w[8*k+:8] = wd[8*k+:8]; p[k] = ^wd[8*k+:8] ^ inj; end
                        epe[i] = bpar(w) != p;
                    end
                    erd[i] = w;
                end
                if (we && int'(wa) < dep[i])
                    for (int k = 0; k < 4; k++)
                        if (be[k]) begin mm[i][wa][8*k+:8] = wd[8*k+:8]; mp[i][wa][k] = ^wd[8*k+:8] ^ inj; end
            end
        end
    endtask
    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_busy", i), 32'(busy[i]), 32'(bc[i] > 0));
            chk($sformatf("u%0d_valid", i), 32'(rv[i]), 32'(erv[i]));
            chk($sformatf("u%0d_data", i), rdd[i], erd[i]);
            chk($sformatf("u%0d_perr", i), 32'(pe[i]), 32'(epe[i]));
        end
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask
    task automatic op(input logic w, input logic [3:0] b, input logic [4:0] a, input logic [31:0] d,
                      input logic r, input logic [4:0] q);
        we = w; be = b; wa = a; wd = d; re = r; ra = q;
        tick();
        we = 1'b0; re = 1'b0;
    endtask
    task automatic busy_len(input string n);
        int c;
        c = 0;
        while (busy[0] && c < 100) begin tick(); c++; end
        chk(n, 32'(c), 32'd32);
    endtask
    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [31:0] e0, e1;
    } vec_t;
    vec_t tbl [12];
    initial begin
        tbl[0]  = '{1, 4'hF, 3,  32'hDEADBEEF, 0, 0,  0, 0};
        tbl[1]  = '{1, 4'h1, 3,  32'h000000AA, 0, 0,  0, 0};
        tbl[2]  = '{0, 4'h0, 0,  0,            1, 3,  32'hDEADBEAA, 32'hDEADBEAA};
        tbl[3]  = '{1, 4'hF, 7,  32'hCAFEF00D, 0, 0,  0, 0};
        tbl[4]  = '{1, 4'hF, 7,  32'h12345678, 1, 7,  32'hCAFEF00D, 32'h12345678};
        tbl[5]  = '{0, 4'h0, 0,  0,            1, 7,  32'h12345678, 32'h12345678};
        tbl[6]  = '{1, 4'hF, 19, 32'h11223344, 0, 0,  0, 0};
        tbl[7]  = '{1, 4'hF, 25, 32'h55667788, 0, 0,  0, 0};
        tbl[8]  = '{0, 4'h0, 0,  0,            1, 25, 32'h55667788, 32'h0};
        tbl[9]  = '{1, 4'h0, 5,  32'hA5A5A5A5, 1, 19, 32'h11223344, 32'h11223344};
        tbl[10] = '{1, 4'hA, 10, 32'hFFFFFFFF, 1, 5,  32'h0, 32'h0};
        tbl[11] = '{0, 4'h0, 0,  0,            1, 10, 32'hFF00FF00, 32'hFF00FF00};
        rst = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0; inj = 1'b0;
        be = '0; wa = '0; ra = '0; wd = '0;
        #2;
        model_reset();
        compare_all();
        tick();
        tick();
        rst = 1'b0;
        busy_len("clear_after_reset");
        for (int a = 0; a < 32; a++) op(1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 5'(a));
        tick();
        for (int i = 0; i < 12; i++) begin
            op(tbl[i].we, tbl[i].be, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
            if (tbl[i].re) begin
                chk($sformatf("tbl%0d_u0", i), rdd[0], tbl[i].e0);
                chk($sformatf("tbl%0d_u1", i), rdd[1], tbl[i].e1);
                chk($sformatf("tbl%0d_valid", i), 32'({rv[1], rv[0]}), 32'd3);
            end
        end
        op(1'b1, 4'hF, 5'd1, 32'h77777777, 1'b0, 5'd0);
        clear = 1'b1;
        op(1'b1, 4'hF, 5'd1, 32'h99999999, 1'b1, 5'd1);
        clear = 1'b0;
        busy_len("clear_request");
        op(1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 5'd1);
        chk("addr1_after_clear", rdd[0], 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        rst = 1'b0;
        busy_len("clear_after_midreset");
`ifdef RAM_PARITY_EN
        op(1'b1, 4'hF, 5'd2, 32'h0F0F0F0F, 1'b0, 5'd0);
        inj = 1'b1;
        op(1'b1, 4'h4, 5'd2, 32'h0F0F0F0F, 1'b0, 5'd0);
        inj = 1'b0;
        op(1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 5'd2);
        chk("par_inj_data", rdd[0], 32'h0F0F0F0F);
        chk("par_inj_err", 32'(pe[0]), 32'd1);
        op(1'b1, 4'hF, 5'd2, 32'h0F0F0F0F, 1'b0, 5'd0);
        op(1'b0, 4'h0, 5'd0, 32'd0, 1'b1, 5'd2);
        chk("par_clean_err", 32'(pe[0]), 32'd0);
`endif
        for (int n = 0; n < 600; n++) begin
            clear = ($urandom_range(0, 99) == 0);
`ifdef RAM_PARITY_EN
            inj = ($urandom_range(0, 7) == 0);
`endif
            op(1'($urandom), 4'($urandom), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom), ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
        end
        clear = 1'b0; inj = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
